// File: rtl/mii_pkg.sv
// Shared types and constants for the 100BASE MII status link (receive checker and transmit stage).
package mii_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_FCS,
        ST_TAIL,
        ST_DROP
    } rx_state_t;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
    localparam logic [3:0]  PREAMBLE_NIB    = 4'h5;
    localparam logic [3:0]  SFD_NIB         = 4'hD;

endpackage

// File: rtl/crc32_nibble.sv
// Combinational reflected CRC-32 step: folds one LSB-first nibble into the running CRC.
module crc32_nibble
    import mii_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [3:0]  i_nib,
    output logic [31:0] o_crc
);

    logic [31:0] w_stage [0:4];

    assign w_stage[0] = i_crc ^ {28'd0, i_nib};

    // One shift-and-conditional-xor per input bit, LSB first.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bit
            assign w_stage[gi+1] = w_stage[gi][0]
                                 ? ({1'b0, w_stage[gi][31:1]} ^ CRC32_POLY_REFL)
                                 :  {1'b0, w_stage[gi][31:1]};
        end
    endgenerate

    assign o_crc = w_stage[4];

endmodule

// File: rtl/mii_rx_status_check.sv
// MII receive checker: strips preamble/SFD, captures the status payload and FCS, verifies CRC-32.
// Optional MII_RX_STATS_EN adds saturating good/bad frame counters.
module mii_rx_status_check
    import mii_pkg::*;
#(
    parameter int PAYLOAD_NIB = 16,
    parameter int MIN_PRE_NIB = 7
)
(
    input  logic                     clk_25Mz,
    input  logic                     rst,
    input  logic                     RX_DV,
    input  logic [3:0]               RXD,
    input  logic                     RX_ER,
    output logic [4*PAYLOAD_NIB-1:0] rx_payload,
    output logic [31:0]              rx_crc,
    output logic                     rx_valid,
    output logic                     crc_ok,
    output logic                     frame_err,
    output logic                     check_receive
`ifdef MII_RX_STATS_EN
    ,
    output logic [15:0]              good_cnt,
    output logic [15:0]              bad_cnt
`endif
);

    localparam int PW    = 4 * PAYLOAD_NIB;
    localparam int NIB_W = $clog2(PAYLOAD_NIB > 8 ? PAYLOAD_NIB : 8);

    rx_state_t         r_state;
    rx_state_t         w_state_next;
    logic [3:0]        r_pre_cnt;
    logic [NIB_W-1:0]  r_nib_cnt;
    logic [31:0]       r_crc;
    logic [31:0]       w_crc_next;
    logic [PW-1:0]     r_pay_sh;
    logic [31:0]       r_fcs_sh;
    logic              r_err;
    logic              r_reached_data;

    logic [PW-1:0]     r_rx_payload;
    logic [31:0]       r_rx_crc;
    logic              r_rx_valid;
    logic              r_crc_ok;
    logic              r_frame_err;
    logic              r_check_receive;

    logic              w_issue;
    logic              w_issue_ok;
    logic              w_issue_err;
    logic              w_issue_full;

    crc32_nibble u_crc (
        .i_crc (r_crc),
        .i_nib (RXD),
        .o_crc (w_crc_next)
    );

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_issue_ok   = 1'b0;
        w_issue_err  = 1'b0;
        w_issue_full = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (RX_DV)
                    w_state_next = (RXD == PREAMBLE_NIB) ? ST_PRE : ST_DROP;
            end
            ST_PRE: begin
                if (!RX_DV) begin
                    w_state_next = ST_IDLE;
                    w_issue      = 1'b1;
                    w_issue_err  = 1'b1;
                end else if (RXD == PREAMBLE_NIB) begin
                    w_state_next = ST_PRE;
                end else if (RXD == SFD_NIB && r_pre_cnt >= 4'(MIN_PRE_NIB)) begin
                    w_state_next = ST_DATA;
                end else begin
                    w_state_next = ST_DROP;
                end
            end
            ST_DATA: begin
                if (!RX_DV) begin
                    w_state_next = ST_IDLE;
                    w_issue      = 1'b1;
                    w_issue_err  = 1'b1;
                end else if (r_nib_cnt == NIB_W'(PAYLOAD_NIB - 1)) begin
                    w_state_next = ST_FCS;
                end
            end
            ST_FCS: begin
                if (!RX_DV) begin
                    w_state_next = ST_IDLE;
                    w_issue      = 1'b1;
                    w_issue_err  = 1'b1;
                end else if (r_nib_cnt == NIB_W'(7)) begin
                    w_state_next = ST_TAIL;
                end
            end
            ST_TAIL: begin
                if (!RX_DV) begin
                    w_state_next = ST_IDLE;
                    w_issue      = 1'b1;
                    w_issue_full = 1'b1;
                    w_issue_err  = r_err;
                    w_issue_ok   = !r_err && (r_crc == CRC32_RESIDUE);
                end else begin
                    w_state_next = ST_DROP;
                end
            end
            ST_DROP: begin
                if (!RX_DV) begin
                    w_state_next = ST_IDLE;
                    w_issue      = r_reached_data;
                    w_issue_err  = r_reached_data;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_25Mz or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_pre_cnt       <= 4'd0;
            r_nib_cnt       <= '0;
            r_crc           <= CRC32_INIT;
            r_pay_sh        <= '0;
            r_fcs_sh        <= 32'd0;
            r_err           <= 1'b0;
            r_reached_data  <= 1'b0;
            r_rx_payload    <= '0;
            r_rx_crc        <= 32'd0;
            r_rx_valid      <= 1'b0;
            r_crc_ok        <= 1'b0;
            r_frame_err     <= 1'b0;
            r_check_receive <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_rx_valid <= w_issue;

            if (w_issue) begin
                r_crc_ok    <= w_issue_ok;
                r_frame_err <= w_issue_err;
                if (w_issue_ok)
                    r_check_receive <= 1'b1;
                // Only complete-length frames replace the reported payload/FCS.
                if (w_issue_full) begin
                    r_rx_payload <= r_pay_sh;
                    r_rx_crc     <= r_fcs_sh;
                end
            end

            if (r_state != ST_IDLE && RX_DV && RX_ER)
                r_err <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    r_pre_cnt      <= 4'd1;
                    r_err          <= 1'b0;
                    r_reached_data <= 1'b0;
                end
                ST_PRE: begin
                    if (RX_DV && RXD == PREAMBLE_NIB && r_pre_cnt != 4'hF)
                        r_pre_cnt <= r_pre_cnt + 4'd1;
                    if (w_state_next == ST_DATA) begin
                        r_crc          <= CRC32_INIT;
                        r_nib_cnt      <= '0;
                        r_reached_data <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (RX_DV) begin
                        r_pay_sh  <= {RXD, r_pay_sh[PW-1:4]};
                        r_crc     <= w_crc_next;
                        r_nib_cnt <= (r_nib_cnt == NIB_W'(PAYLOAD_NIB - 1)) ? '0 : r_nib_cnt + 1'b1;
                    end
                end
                ST_FCS: begin
                    if (RX_DV) begin
                        r_fcs_sh  <= {RXD, r_fcs_sh[31:4]};
                        r_crc     <= w_crc_next;
                        r_nib_cnt <= r_nib_cnt + 1'b1;
                    end
                end
                ST_TAIL: begin
                    if (RX_DV)
                        r_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rx_payload    = r_rx_payload;
    assign rx_crc        = r_rx_crc;
    assign rx_valid      = r_rx_valid;
    assign crc_ok        = r_crc_ok;
    assign frame_err     = r_frame_err;
    assign check_receive = r_check_receive;

`ifdef MII_RX_STATS_EN
    logic [15:0] r_good_cnt;
    logic [15:0] r_bad_cnt;

    always_ff @(posedge clk_25Mz or posedge rst) begin
        if (rst) begin
            r_good_cnt <= 16'd0;
            r_bad_cnt  <= 16'd0;
        end else if (w_issue) begin
            if (w_issue_ok && !w_issue_err) begin
                if (r_good_cnt != 16'hFFFF)
                    r_good_cnt <= r_good_cnt + 16'd1;
            end else if (r_bad_cnt != 16'hFFFF) begin
                r_bad_cnt <= r_bad_cnt + 16'd1;
            end
        end
    end

    assign good_cnt = r_good_cnt;
    assign bad_cnt  = r_bad_cnt;
`endif

endmodule

// File: tb/tb_mii_rx_status_check.sv
// Directed bench for mii_rx_status_check; define MII_RX_STATS_EN to also check the frame counters.
module tb_mii_rx_status_check;

    logic        clk_25Mz = 1'b0;
    logic        rst      = 1'b1;
    logic        RX_DV    = 1'b0;
    logic [3:0]  RXD      = 4'h0;
    logic        RX_ER    = 1'b0;
    logic [63:0] rx_payload;
    logic [31:0] rx_crc;
    logic        rx_valid;
    logic        crc_ok;
    logic        frame_err;
    logic        check_receive;
`ifdef MII_RX_STATS_EN
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;
`endif

    int checks    = 0;
    int failures  = 0;
    int pulse_cnt = 0;
    int exp_pulses = 0;
    int exp_good  = 0;
    int exp_bad   = 0;

    mii_rx_status_check #(.PAYLOAD_NIB(16), .MIN_PRE_NIB(7)) dut (
        .clk_25Mz      (clk_25Mz),
        .rst           (rst),
        .RX_DV         (RX_DV),
        .RXD           (RXD),
        .RX_ER         (RX_ER),
        .rx_payload    (rx_payload),
        .rx_crc        (rx_crc),
        .rx_valid      (rx_valid),
        .crc_ok        (crc_ok),
        .frame_err     (frame_err),
        .check_receive (check_receive)
`ifdef MII_RX_STATS_EN
        ,
        .good_cnt      (good_cnt),
        .bad_cnt       (bad_cnt)
`endif
    );

    always #20 clk_25Mz = ~clk_25Mz;

    always @(posedge clk_25Mz) if (rx_valid) pulse_cnt <= pulse_cnt + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reflected CRC-32 over 64 bits, LSB first, returning the FCS to transmit.
    function automatic logic [31:0] fcs_of(input logic [63:0] d);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < 64; i++)
            c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return ~c;
    endfunction

    task automatic drive(input logic dv, input logic [3:0] d, input logic er);
        @(negedge clk_25Mz);
        RX_DV = dv;
        RXD   = d;
        RX_ER = er;
    endtask

    task automatic send_frame(input logic [63:0] pay, input logic [31:0] fcs, input int npre,
                              input int nsend, input int er_at, input bit end_frame);
        logic [3:0] nib;
        for (int p = 0; p < npre; p++) drive(1'b1, 4'h5, 1'b0);
        drive(1'b1, 4'hD, 1'b0);
        for (int i = 0; i < nsend; i++) begin
            if (i < 16)      nib = pay[4*i +: 4];
            else if (i < 24) nib = fcs[4*(i-16) +: 4];
            else             nib = 4'h3;
            drive(1'b1, nib, (i == er_at));
        end
        if (end_frame) drive(1'b0, 4'h0, 1'b0);
    endtask

    // Called after the idle nibble that ends a frame: the result pulse is visible now.
    task automatic expect_result(input string tag, input logic ok, input logic err);
        @(negedge clk_25Mz);
        $display("frame %s: rx_valid=%0b crc_ok=%0b frame_err=%0b payload=%h rx_crc=%h",
                 tag, rx_valid, crc_ok, frame_err, rx_payload, rx_crc);
        check({tag, ".rx_valid"}, 64'(rx_valid), 64'd1);
        check({tag, ".crc_ok"}, 64'(crc_ok), 64'(ok));
        check({tag, ".frame_err"}, 64'(frame_err), 64'(err));
        exp_pulses++;
        if (ok && !err) exp_good++; else exp_bad++;
    endtask

    task automatic check_pulses(input string tag);
        @(negedge clk_25Mz);
        check({tag, ".pulses"}, 64'(pulse_cnt), 64'(exp_pulses));
    endtask

    logic [63:0] pay0, pay1, pay2, pay3;
    logic [31:0] fcs0, fcs1, fcs2, fcs3;

    initial begin
        pay0 = 64'hFFFFFFFF00000000;
        pay1 = 64'h0123456789ABCDEF;
        pay2 = 64'hA5A50F0F12345678;
        pay3 = 64'h00000000DEADBEEF;
        fcs0 = fcs_of(pay0);
        fcs1 = fcs_of(pay1);
        fcs2 = fcs_of(pay2);
        fcs3 = fcs_of(pay3);

        repeat (3) @(negedge clk_25Mz);
        check("reset.rx_valid", 64'(rx_valid), 64'd0);
        check("reset.crc_ok", 64'(crc_ok), 64'd0);
        check("reset.frame_err", 64'(frame_err), 64'd0);
        check("reset.check_receive", 64'(check_receive), 64'd0);
        check("reset.rx_payload", rx_payload, 64'd0);
        check("reset.rx_crc", 64'(rx_crc), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk_25Mz);

        send_frame(pay0, fcs0 ^ 32'h1, 15, 24, -1, 1'b1);
        expect_result("bad_fcs", 1'b0, 1'b0);
        check("bad_fcs.check_receive", 64'(check_receive), 64'd0);
        check("bad_fcs.rx_payload", rx_payload, pay0);
        check("bad_fcs.rx_crc", 64'(rx_crc), 64'(fcs0 ^ 32'h1));

        send_frame(pay0, fcs0, 15, 24, -1, 1'b1);
        expect_result("good", 1'b1, 1'b0);
        check("good.check_receive", 64'(check_receive), 64'd1);
        check("good.rx_payload", rx_payload, pay0);
        check("good.rx_crc", 64'(rx_crc), 64'(fcs0));
        @(negedge clk_25Mz);
        check("good.pulse_one_cycle", 64'(rx_valid), 64'd0);
        check("good.crc_ok_held", 64'(crc_ok), 64'd1);

        send_frame(pay1, fcs1, 15, 10, -1, 1'b1);
        expect_result("runt", 1'b0, 1'b1);
        check("runt.rx_payload_kept", rx_payload, pay0);
        check("runt.check_receive_held", 64'(check_receive), 64'd1);

        send_frame(pay1, fcs1, 15, 25, -1, 1'b1);
        expect_result("long", 1'b0, 1'b1);
        check("long.rx_payload_kept", rx_payload, pay0);

        send_frame(pay1, fcs1, 15, 24, 5, 1'b1);
        expect_result("rx_er", 1'b0, 1'b1);

        // Short preamble is dropped silently; next frame follows after a single idle cycle.
        send_frame(pay1, fcs1, 3, 24, -1, 1'b1);
        send_frame(pay2, fcs2, 15, 24, -1, 1'b1);
        expect_result("after_short_pre", 1'b1, 1'b0);
        check("after_short_pre.rx_payload", rx_payload, pay2);
        check_pulses("short_pre");

        send_frame(pay3, fcs3, 6, 24, -1, 1'b1);
        check_pulses("pre6_silent");
        send_frame(pay3, fcs3, 7, 24, -1, 1'b1);
        expect_result("pre7", 1'b1, 1'b0);
        check("pre7.rx_payload", rx_payload, pay3);

        send_frame(pay2, fcs2, 15, 20, -1, 1'b0);
        @(negedge clk_25Mz);
        rst   = 1'b1;
        RX_DV = 1'b0;
        @(negedge clk_25Mz);
        check("midrst.rx_valid", 64'(rx_valid), 64'd0);
        check("midrst.crc_ok", 64'(crc_ok), 64'd0);
        check("midrst.frame_err", 64'(frame_err), 64'd0);
        check("midrst.check_receive", 64'(check_receive), 64'd0);
        check("midrst.rx_payload", rx_payload, 64'd0);
        check("midrst.rx_crc", 64'(rx_crc), 64'd0);
        rst = 1'b0;
        exp_good = 0;
        exp_bad  = 0;
        check_pulses("midrst");
        send_frame(pay1, fcs1, 15, 24, -1, 1'b1);
        expect_result("after_rst", 1'b1, 1'b0);
        check("after_rst.check_receive", 64'(check_receive), 64'd1);
        check("after_rst.rx_payload", rx_payload, pay1);

`ifdef MII_RX_STATS_EN
        send_frame(pay0, fcs0 ^ 32'h80000000, 15, 24, -1, 1'b1);
        expect_result("stats_bad1", 1'b0, 1'b0);
        send_frame(pay0, fcs0, 15, 12, -1, 1'b1);
        expect_result("stats_bad2", 1'b0, 1'b1);
        @(negedge clk_25Mz);
        check("stats.good_cnt", 64'(good_cnt), 64'(exp_good));
        check("stats.bad_cnt", 64'(bad_cnt), 64'(exp_bad));
`endif

        check_pulses("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
